// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side handshake bundle for sram_arbiter.
//
// Carries both requester channels:
//   IF  : read-only request (valid/ready/addr), response (valid/ready/data)
//   MEM : read/write request (valid/ready/addr/we/wdata), response
//         (valid/ready/data; data is 0 for write acks)
// Modports:
//   slave  - the arbiter side (accepts requests, produces responses)
//   master - the requester side (issues requests, consumes responses)
interface sram_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_resp_valid;
    logic              if_resp_ready;
    logic [DATA_W-1:0] if_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [MASK_W-1:0] mem_req_we;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  if_req_valid, if_req_addr, if_resp_ready,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_resp_ready,
        output if_req_ready, if_resp_valid, if_resp_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output if_req_valid, if_req_addr, if_resp_ready,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_resp_ready,
        input  if_req_ready, if_resp_valid, if_resp_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM (1-cycle registered read) between
// instruction fetch (read-only) and load/store (read/write). One transaction
// is in flight at a time: IDLE (grant + SRAM access) -> CAPT (capture read
// data) -> RESP (hold response until the owner accepts it).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          sram_arbiter_if.slave - IF and MEM request/response handshakes
//   sram_en/we/addr/wdata  command to the SRAM
//   sram_rdata   SRAM read data, valid the cycle after the address
//
// Configuration macro: SRAM_ARB_RR_EN
//   defined   - round-robin between IF and MEM when both request together
//   undefined - fixed priority, MEM over IF
module sram_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_arbiter_if.slave     bus,
    output logic              sram_en,
    output logic [MASK_W-1:0] sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {IDLE, CAPT, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;        // 1 = MEM owns the transaction
    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic              grant_if, grant_mem;
    logic              en_c;
    logic [MASK_W-1:0] we_c;
    logic [ADDR_W-1:0] addr_c;
    logic              owner_resp_ready;

`ifdef SRAM_ARB_RR_EN
    // rr_q names the preferred requester on contention: 0 = IF, 1 = MEM.
    logic rr_q, rr_d;
    logic contended;

    always_comb begin
        contended = (state_q == IDLE) && bus.if_req_valid && bus.mem_req_valid;
        grant_mem = (state_q == IDLE) && bus.mem_req_valid && (!bus.if_req_valid || rr_q);
        grant_if  = (state_q == IDLE) && bus.if_req_valid && (!bus.mem_req_valid || !rr_q);
        rr_d      = contended ? ~rr_q : rr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
`else
    always_comb begin
        grant_mem = (state_q == IDLE) && bus.mem_req_valid;
        grant_if  = (state_q == IDLE) && bus.if_req_valid && !bus.mem_req_valid;
    end
`endif

    assign owner_resp_ready = owner_q ? bus.mem_resp_ready : bus.if_resp_ready;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        resp_data_d = resp_data_q;
        en_c        = 1'b0;
        we_c        = '0;
        addr_c      = addr_q;

        case (state_q)
            IDLE: begin
                if (grant_mem || grant_if) begin
                    en_c       = 1'b1;
                    addr_c     = grant_mem ? bus.mem_req_addr : bus.if_req_addr;
                    we_c       = grant_mem ? bus.mem_req_we : '0;
                    owner_d    = grant_mem;
                    is_write_d = grant_mem && (|bus.mem_req_we);
                    addr_d     = addr_c;
                    state_d    = CAPT;
                end
            end
            CAPT: begin
                // SRAM read data is valid now, one cycle after the address.
                resp_data_d = is_write_q ? '0 : sram_rdata;
                state_d     = RESP;
            end
            RESP: begin
                if (owner_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Grants are combinational from the request valids, so they are masked
    // while reset is asserted to keep readies and SRAM strobes quiet.
    assign bus.if_req_ready   = grant_if  && rst_n;
    assign bus.mem_req_ready  = grant_mem && rst_n;
    assign sram_en            = en_c && rst_n;
    assign sram_we            = rst_n ? we_c : '0;
    assign sram_addr          = rst_n ? addr_c : '0;
    assign sram_wdata         = bus.mem_req_wdata;

    assign bus.if_resp_valid  = (state_q == RESP) && !owner_q;
    assign bus.mem_resp_valid = (state_q == RESP) && owner_q;
    assign bus.if_resp_data   = resp_data_q;
    assign bus.mem_resp_data  = resp_data_q;

endmodule
